// File: rtl/dstack_regs.sv
// Data-stack storage: a shift-register stack with top/second/third taps,
// a combinational random-access read port, occupancy count and sticky error flags.
module dstack_regs #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  halt,
    input  logic [1:0]            movement,
    input  logic [WORD_WIDTH-1:0] next_top,
    input  logic                  rotate,
    input  logic [5:0]            rotate_addr,
    input  logic                  clear_flags,
    output logic [WORD_WIDTH-1:0] top,
    output logic [WORD_WIDTH-1:0] second,
    output logic [WORD_WIDTH-1:0] third,
    output logic [WORD_WIDTH-1:0] rotate_value,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    // Every 6-bit rotate_addr must land on a real entry.
    generate
        if (DEPTH < 64) begin : g_depth_check
            $error("dstack_regs: DEPTH must be at least 64");
        end
    endgenerate

    logic [WORD_WIDTH-1:0] e [DEPTH];
    logic [CW-1:0]         rotate_addr_ext;

    assign rotate_addr_ext = {{(CW-6){1'b0}}, rotate_addr};

    assign top          = e[0];
    assign second       = e[1];
    assign third        = e[2];
    assign rotate_value = e[rotate_addr];

    // Later assignments in this block win, so flag sets override clear_flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                e[i] <= '0;
            end
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (!halt) begin
            if (clear_flags) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            e[0] <= next_top;
            if (rotate) begin
                for (int i = 1; i < DEPTH; i++) begin
                    if (i <= int'(rotate_addr)) begin
                        e[i] <= e[i-1];
                    end
                end
                if (rotate_addr_ext >= count) begin
                    underflow <= 1'b1;
                end
            end else begin
                case (movement)
                    2'b01: begin
                        for (int i = 1; i < DEPTH; i++) begin
                            e[i] <= e[i-1];
                        end
                        if (count == CW'(DEPTH)) begin
                            overflow <= 1'b1;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                    2'b10: begin
                        for (int i = 1; i < DEPTH - 1; i++) begin
                            e[i] <= e[i+1];
                        end
                        e[DEPTH-1] <= '0;
                        if (count == '0) begin
                            underflow <= 1'b1;
                        end else begin
                            count <= count - CW'(1);
                        end
                    end
                    2'b11: begin
                        for (int i = 1; i < DEPTH - 2; i++) begin
                            e[i] <= e[i+2];
                        end
                        e[DEPTH-2] <= '0;
                        e[DEPTH-1] <= '0;
                        if (count < CW'(2)) begin
                            underflow <= 1'b1;
                            count     <= '0;
                        end else begin
                            count <= count - CW'(2);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
